csr_counter_responder: RTL and testbench
========================================

// Module: csr_counter_responder
// PURPOSE
//  CSR-side responder for the commit-stage CSR request interface, for the counter CSR group only.
//  Decodes CSR read/write commands and returns read data plus an illegal-access flag after one cycle.
//  Keeps mcycle/minstret and their user aliases, counting from the 2-bit per-cycle retire vector.
//  Sits in the CSR unit, parallel to the main CSR file; the CSR-file mux selects its response by address.
// PARAMETERS
//  CNT_WIDTH   64   counter width; write data truncated to it, read data zero-extended to 64
// PORTS
//  clk_i            in   1    clock
//  rstn_i           in   1    synchronous active-low reset
//  csr_rw_addr_i    in   12   CSR address (valid when cmd != NOPE)
//  csr_rw_cmd_i     in   3    csr_cmd_t: NOPE/READ/WRITE/RW/SET/CLEAR; other encodings = NOPE
//  csr_rw_data_i    in   64   write/set/clear operand
//  csr_retire_i     in   2    per-slot retire bits; popcount is added to minstret
//  csr_exception_i  in   1    commit exception/flush this cycle
//  priv_lvl_i       in   2    current privilege: 0=U, 1=S, 3=M
//  csr_resp_valid_o out  1    response valid (one-cycle pulse)
//  csr_rdata_o      out  64   read data (old value)
//  csr_xcpt_o       out  1    illegal CSR access; qualified by csr_resp_valid_o
//  csr_stall_o      out  1    responder busy; requester must hold its request
// BEHAVIOUR
//  Reset (rstn_i=0 at a clk_i edge): mcycle=minstret=mcounteren=0, FSM=IDLE, all outputs 0.
//  Address map: mcycle 0xB00, minstret 0xB02, mcounteren 0x306 (bits [2:0] kept, reads rest 0),
//    cycle 0xC00 and instret 0xC02 (read-only aliases). Any other address is illegal.
//  FSM IDLE: cmd != NOPE and !csr_exception_i -> capture the request, go to RESP.
//  FSM RESP: csr_resp_valid_o=1, csr_stall_o=1; always returns to IDLE next cycle.
//    A request presented in RESP is not captured; the requester holds it until IDLE.
//  Latency: request accepted at edge N -> response in cycle N+1 -> next accept at edge N+2.
//  rdata = register value sampled at edge N (pre-write); 0 when illegal.
//  Write value: WRITE/RW = data; SET = old|data; CLEAR = old&~data; READ = no write.
//    SET/CLEAR with data==0 never write and never raise a read-only fault.
//  Write timing: committed at edge N only if legal; the new value is readable from cycle N+1.
//  Illegal (xcpt=1, no state change):
//    - unmapped address;
//    - any write to 0xC00/0xC02;
//    - priv < M accessing 0xB00/0xB02/0x306;
//    - priv < M reading 0xC00 with mcounteren[0]=0, or reading 0xC02 with mcounteren[2]=0.
//  mcycle: +1 every cycle out of reset; a same-cycle write overrides the increment.
//  minstret: += popcount(csr_retire_i) (0..2) every cycle; a same-cycle write overrides it.
//  Wrap-around: counters wrap modulo 2^CNT_WIDTH; max-1 plus 2 retires = 0.
//  Flush: csr_exception_i blocks capture in IDLE. In RESP the response still completes
//    (state already committed). Retire counting does not depend on csr_exception_i.
// CONFIGURATION
//  CSR_COUNTINHIBIT_EN defined:
//    - adds mcountinhibit 0x320 (bits 0 and 2 kept; M-only; reset 0);
//    - bit0=1 freezes mcycle increment; bit2=1 freezes minstret increment;
//    - CSR writes to the counters still apply while frozen.
//  CSR_COUNTINHIBIT_EN undefined: 0x320 is illegal; counters never freeze.
// TESTING
//  Reset, then idle 10 cycles, then READ 0xB00 in M -> rdata=10; xcpt=0; resp_valid 1 cycle after request.
//  WRITE 0xB02 data=5 with retire=2'b11 same cycle -> next READ 0xB02 returns 5 + retires since the write.
//  U-mode READ 0xC02, mcounteren=0 -> xcpt=1, rdata=0. Set mcounteren=4, retry -> xcpt=0, value=minstret.
//  Boundary cases:
//    - WRITE 0xC00 -> xcpt=1, counter unchanged;
//    - SET 0xC00 data=0 -> xcpt=0;
//    - request with csr_exception_i=1 -> no response.
//  Wrap: WRITE minstret = 2^64-1, then retire=2'b11 -> minstret=1; back-to-back requests -> stall_o=1 in RESP.
//  CSR_COUNTINHIBIT_EN: write 0x320=1 -> mcycle holds across 20 cycles; write 0 -> resumes +1/cycle.

Source files
------------

// File: rtl/csr_counter_responder.sv
// Counter CSR group responder (mcycle/minstret, cycle/instret aliases, mcounteren).
// Optional mcountinhibit at 0x320 when CSR_COUNTINHIBIT_EN is defined.
module csr_counter_responder #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [11:0] csr_rw_addr_i,
  input  logic [2:0]  csr_rw_cmd_i,
  input  logic [63:0] csr_rw_data_i,
  input  logic [1:0]  csr_retire_i,
  input  logic        csr_exception_i,
  input  logic [1:0]  priv_lvl_i,
  output logic        csr_resp_valid_o,
  output logic [63:0] csr_rdata_o,
  output logic        csr_xcpt_o,
  output logic        csr_stall_o
);

  localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
  localparam logic [11:0] ADDR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] ADDR_CYCLE      = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET    = 12'hC02;
`ifdef CSR_COUNTINHIBIT_EN
  localparam logic [11:0] ADDR_MCNTINHIB  = 12'h320;
`endif

  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_RW    = 3'd3;
  localparam logic [2:0] CMD_SET   = 3'd4;
  localparam logic [2:0] CMD_CLEAR = 3'd5;

  typedef enum logic {IDLE, RESP} state_e;

  state_e               state, state_next;
  logic [CNT_WIDTH-1:0] mcycle, minstret;
  logic [2:0]           mcounteren;
  logic [63:0]          rdata_q;
  logic                 xcpt_q;

  logic        cmd_valid, does_write, accept;
  logic [63:0] old_val, wval;
  logic        mapped, m_only, read_only, cnt_ok, is_m, illegal;
  logic        we_mcycle, we_minstret, we_mcounteren;
  logic        cy_inc, ir_en;

`ifdef CSR_COUNTINHIBIT_EN
  logic inhibit_cy, inhibit_ir;
  logic we_inhibit;
  assign cy_inc = ~inhibit_cy;
  assign ir_en  = ~inhibit_ir;
`else
  assign cy_inc = 1'b1;
  assign ir_en  = 1'b1;
`endif

  // Address decode and privilege / counter-enable checks
  always_comb begin
    old_val   = '0;
    mapped    = 1'b0;
    m_only    = 1'b0;
    read_only = 1'b0;
    cnt_ok    = 1'b1;
    case (csr_rw_addr_i)
      ADDR_MCYCLE:     begin old_val = 64'(mcycle);   mapped = 1'b1; m_only = 1'b1; end
      ADDR_MINSTRET:   begin old_val = 64'(minstret); mapped = 1'b1; m_only = 1'b1; end
      ADDR_MCOUNTEREN: begin old_val = {61'b0, mcounteren}; mapped = 1'b1; m_only = 1'b1; end
      ADDR_CYCLE: begin
        old_val = 64'(mcycle); mapped = 1'b1; read_only = 1'b1; cnt_ok = mcounteren[0];
      end
      ADDR_INSTRET: begin
        old_val = 64'(minstret); mapped = 1'b1; read_only = 1'b1; cnt_ok = mcounteren[2];
      end
`ifdef CSR_COUNTINHIBIT_EN
      ADDR_MCNTINHIB: begin
        old_val = {61'b0, inhibit_ir, 1'b0, inhibit_cy}; mapped = 1'b1; m_only = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // SET/CLEAR with a zero operand are pure reads, so they never trip the read-only check
  always_comb begin
    cmd_valid  = 1'b0;
    does_write = 1'b0;
    wval       = '0;
    case (csr_rw_cmd_i)
      CMD_READ:  cmd_valid = 1'b1;
      CMD_WRITE, CMD_RW: begin
        cmd_valid = 1'b1; does_write = 1'b1; wval = csr_rw_data_i;
      end
      CMD_SET: begin
        cmd_valid = 1'b1; does_write = |csr_rw_data_i; wval = old_val | csr_rw_data_i;
      end
      CMD_CLEAR: begin
        cmd_valid = 1'b1; does_write = |csr_rw_data_i; wval = old_val & ~csr_rw_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    is_m    = (priv_lvl_i == 2'b11);
    illegal = ~mapped | (read_only & does_write) | (~is_m & m_only) | (~is_m & ~cnt_ok);
    accept  = (state == IDLE) & cmd_valid & ~csr_exception_i;
    we_mcycle     = accept & ~illegal & does_write & (csr_rw_addr_i == ADDR_MCYCLE);
    we_minstret   = accept & ~illegal & does_write & (csr_rw_addr_i == ADDR_MINSTRET);
    we_mcounteren = accept & ~illegal & does_write & (csr_rw_addr_i == ADDR_MCOUNTEREN);
`ifdef CSR_COUNTINHIBIT_EN
    we_inhibit    = accept & ~illegal & does_write & (csr_rw_addr_i == ADDR_MCNTINHIB);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next       = state;
    csr_resp_valid_o = 1'b0;
    csr_stall_o      = 1'b0;
    case (state)
      IDLE: if (accept) state_next = RESP;
      RESP: begin
        csr_resp_valid_o = 1'b1;
        csr_stall_o      = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mcycle     <= '0;
      minstret   <= '0;
      mcounteren <= '0;
      rdata_q    <= '0;
      xcpt_q     <= 1'b0;
    end else begin
      if (we_mcycle) mcycle <= wval[CNT_WIDTH-1:0];
      else           mcycle <= mcycle + CNT_WIDTH'(cy_inc);
      if (we_minstret) minstret <= wval[CNT_WIDTH-1:0];
      else if (ir_en)  minstret <= minstret + CNT_WIDTH'(csr_retire_i[0])
                                            + CNT_WIDTH'(csr_retire_i[1]);
      if (we_mcounteren) mcounteren <= wval[2:0];
      if (accept) begin
        rdata_q <= illegal ? '0 : old_val;
        xcpt_q  <= illegal;
      end
    end
  end

`ifdef CSR_COUNTINHIBIT_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      inhibit_cy <= 1'b0;
      inhibit_ir <= 1'b0;
    end else if (we_inhibit) begin
      inhibit_cy <= wval[0];
      inhibit_ir <= wval[2];
    end
  end
`endif

  assign csr_rdata_o = rdata_q;
  assign csr_xcpt_o  = xcpt_q;

endmodule

// File: tb/tb_csr_counter_responder.sv
// Directed self-checking bench for csr_counter_responder; expected values are hand-derived
// from the edge count since reset release.
module tb_csr_counter_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] addr;
  logic [2:0]  cmd;
  logic [63:0] data;
  logic [1:0]  retire;
  logic        exc;
  logic [1:0]  priv;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        xcpt;
  logic        stall;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOPE = 3'd0, READ = 3'd1, WRITE = 3'd2, SET = 3'd4;
  localparam logic [1:0] PM = 2'b11, PU = 2'b00;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  csr_counter_responder #(.CNT_WIDTH(64)) dut (
    .clk_i(clk), .rstn_i(rstn), .csr_rw_addr_i(addr), .csr_rw_cmd_i(cmd),
    .csr_rw_data_i(data), .csr_retire_i(retire), .csr_exception_i(exc),
    .priv_lvl_i(priv), .csr_resp_valid_o(resp_valid), .csr_rdata_o(rdata),
    .csr_xcpt_o(xcpt), .csr_stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One request: accepted at the next edge, response checked in the following cycle.
  task automatic req(input string tag, input logic [2:0] c, input logic [11:0] a,
                     input logic [63:0] d, input logic [1:0] p, input logic [1:0] r,
                     input logic exp_x, input logic [63:0] exp_d);
    cmd = c; addr = a; data = d; priv = p; retire = r;
    @(posedge clk); #1;
    cmd = NOPE; retire = 2'b00;
    @(negedge clk);
    chk({tag, ".valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".stall"}, 64'(stall), 64'd1);
    chk({tag, ".xcpt"},  64'(xcpt), 64'(exp_x));
    chk({tag, ".rdata"}, rdata, exp_d);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; addr = '0; cmd = NOPE; data = '0; retire = '0; exc = 1'b0; priv = PM;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(resp_valid), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.xcpt",  64'(xcpt), 64'd0);
    chk("rst.rdata", rdata, 64'd0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    req("rd_mcycle10", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd10);
    req("rd_mcycle12", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd12);
    req("wr_minstret", WRITE, 12'hB02, 64'd5, PM, 2'b11, 1'b0, 64'd0);
    retire = 2'b10;
    @(posedge clk); #1;
    retire = 2'b00;
    req("rd_minstret6", READ, 12'hB02, 64'd0, PM, 2'b00, 1'b0, 64'd6);
    req("wr_mcycle", WRITE, 12'hB00, 64'd100, PM, 2'b00, 1'b0, 64'd19);
    req("rd_mcycle101", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd101);
    req("u_instret_off", READ, 12'hC02, 64'd0, PU, 2'b00, 1'b1, 64'd0);
    req("wr_mcounteren", WRITE, 12'h306, 64'd4, PM, 2'b00, 1'b0, 64'd0);
    req("u_instret_on", READ, 12'hC02, 64'd0, PU, 2'b00, 1'b0, 64'd6);
    req("u_cycle_off", READ, 12'hC00, 64'd0, PU, 2'b00, 1'b1, 64'd0);
    req("u_mcycle", READ, 12'hB00, 64'd0, PU, 2'b00, 1'b1, 64'd0);
    req("wr_mcen_ones", WRITE, 12'h306, ONES, PM, 2'b00, 1'b0, 64'd4);
    req("rd_mcen7", READ, 12'h306, 64'd0, PM, 2'b00, 1'b0, 64'd7);
    req("wr_cycle_ro", WRITE, 12'hC00, 64'd5, PM, 2'b00, 1'b1, 64'd0);
    req("rd_mcycle119", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd119);
    req("set_cycle_0", SET, 12'hC00, 64'd0, PM, 2'b00, 1'b0, 64'd121);

    // Request under a commit flush must not be captured
    cmd = READ; addr = 12'hB00; priv = PM; exc = 1'b1;
    @(posedge clk); #1;
    cmd = NOPE; exc = 1'b0;
    @(negedge clk);
    chk("flush.valid", 64'(resp_valid), 64'd0);
    chk("flush.stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    req("wr_minstret_max", WRITE, 12'hB02, ONES, PM, 2'b00, 1'b0, 64'd6);
    retire = 2'b11;
    @(posedge clk); #1;
    retire = 2'b00;
    req("rd_minstret_wrap", READ, 12'hB02, 64'd0, PM, 2'b00, 1'b0, 64'd1);
    req("wr_mcycle_max", WRITE, 12'hB00, ONES, PM, 2'b00, 1'b0, 64'd130);
    req("rd_mcycle_wrap", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd0);

    // Request held through RESP is only taken again once back in IDLE
    cmd = READ; addr = 12'hB00; priv = PM;
    @(posedge clk);
    @(negedge clk);
    chk("hold1.valid", 64'(resp_valid), 64'd1);
    chk("hold1.stall", 64'(stall), 64'd1);
    chk("hold1.rdata", rdata, 64'd2);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle.valid", 64'(resp_valid), 64'd0);
    chk("hold_idle.stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    cmd = NOPE;
    @(negedge clk);
    chk("hold2.valid", 64'(resp_valid), 64'd1);
    chk("hold2.rdata", rdata, 64'd4);
    @(posedge clk); #1;

`ifdef CSR_COUNTINHIBIT_EN
    req("wr_inhibit1", WRITE, 12'h320, 64'd1, PM, 2'b00, 1'b0, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    req("rd_frozen", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd7);
    req("wr_inhibit0", WRITE, 12'h320, 64'd0, PM, 2'b00, 1'b0, 64'd1);
    req("rd_resume8", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd8);
    req("rd_resume10", READ, 12'hB00, 64'd0, PM, 2'b00, 1'b0, 64'd10);
`else
    req("rd_320_illegal", READ, 12'h320, 64'd0, PM, 2'b00, 1'b1, 64'd0);
`endif
    req("rd_unmapped", READ, 12'h123, 64'd0, PM, 2'b00, 1'b1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
